// File: rtl/prog_instr_mem.sv
// prog_instr_mem: byte-loaded program memory with a single-cycle, fault-checked
// big-endian instruction fetch port.
module prog_instr_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [7:0]    load_data,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_pc,
  input  logic          fetch_stall,
  output logic          ready,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [AW:0]   prog_len,
  output logic          load_ovf
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t      state_q;
  logic [AW:0] ptr_q, len_q;
  logic        ovf_q, valid_q, fault_q;
  logic [31:0] instr_q;
  logic [1:0]  code_q, code_d;
  logic [7:0]  mem [DEPTH];
  logic        start, wr_en, accept;
  logic [AW-1:0] wr_addr, a;
  logic [31:0] word;
  assign start   = load_en && state_q != LOAD;
  assign wr_en   = !rst && load_en && (start || ptr_q != (AW+1)'(DEPTH));
  assign wr_addr = start ? '0 : ptr_q[AW-1:0];
  assign ready   = state_q == RUN && !fetch_stall;
  assign accept  = ready && fetch_req && !load_en;
  assign a       = fetch_pc[AW-1:0];
  // a+4 needs AW+1 bits so a word ending exactly at DEPTH is still in range
  assign code_d  = fetch_pc[1:0] != 2'b00 ? 2'b01 :
                   fetch_pc[31:AW] != '0 ? 2'b10 :
                   ({1'b0, a} + (AW+1)'(4)) > len_q ? 2'b11 : 2'b00;
  assign word    = {mem[a], mem[a + AW'(1)], mem[a + AW'(2)], mem[a + AW'(3)]};
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign prog_len    = len_q;
  assign load_ovf    = ovf_q;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      if (start) begin
        state_q <= LOAD;
        ptr_q   <= (AW+1)'(1);
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else if (state_q == LOAD) begin
        if (load_en) begin
          if (ptr_q == (AW+1)'(DEPTH)) ovf_q <= 1'b1;
          else ptr_q <= ptr_q + (AW+1)'(1);
        end else begin
          len_q   <= ptr_q;
          state_q <= RUN;
        end
      end
      if (!start && !fetch_stall) begin
        valid_q <= accept;
        if (accept) begin
          instr_q <= code_d != 2'b00 ? 32'h0 : word;
          fault_q <= code_d != 2'b00;
          code_q  <= code_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_instr_mem.sv
// tb_prog_instr_mem: directed and randomized checks of prog_instr_mem against a byte-array model.
module tb_prog_instr_mem;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  logic clk = 0, rst = 1, load_en = 0, fetch_req = 0, fetch_stall = 0;
  logic [7:0]  load_data = 0;
  logic [31:0] fetch_pc = 0;
  logic        ready, instr_valid, fault, load_ovf;
  logic [31:0] instr;
  logic [1:0]  fault_code;
  logic [AW:0] prog_len;
  int checks = 0, passes = 0, fails = 0;
  logic [7:0] model_mem [DEPTH];
  int model_len = 0;
  bit model_ovf = 0;
  byte unsigned prog [$];

  prog_instr_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .ready(ready), .instr(instr), .instr_valid(instr_valid), .fault(fault),
    .fault_code(fault_code), .prog_len(prog_len), .load_ovf(load_ovf));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected fetch result straight from the fault rules, with big-endian assembly.
  task automatic expect_fetch(input logic [31:0] pc, output logic [31:0] w, output logic [1:0] c);
    longint p = longint'(pc);
    if (pc[1:0] != 0) c = 2'b01;
    else if (p >= DEPTH) c = 2'b10;
    else if (p + 4 > model_len) c = 2'b11;
    else c = 2'b00;
    w = (c != 0) ? 32'h0 : {model_mem[p], model_mem[p+1], model_mem[p+2], model_mem[p+3]};
  endtask

  task automatic do_load(input bit with_fetch);
    foreach (prog[i]) begin
      load_en = 1;
      load_data = prog[i];
      if (i == 0 && with_fetch) begin fetch_req = 1; fetch_pc = 4; end
      if (i < DEPTH) model_mem[i] = prog[i];
      tick();
      if (i == 0 && with_fetch) begin
        fetch_req = 0;
        chk("load_beats_fetch_valid", {31'b0, instr_valid}, 0);
      end
    end
    load_en = 0;
    tick();
    model_len = prog.size() > DEPTH ? DEPTH : prog.size();
    model_ovf = prog.size() > DEPTH;
    chk("prog_len", {21'b0, prog_len}, model_len);
    chk("load_ovf", {31'b0, load_ovf}, {31'b0, model_ovf});
    chk("ready_after_load", {31'b0, ready}, 1);
  endtask

  task automatic fetch(input logic [31:0] pc);
    logic [31:0] w;
    logic [1:0] c;
    fetch_req = 1;
    fetch_pc = pc;
    tick();
    fetch_req = 0;
    expect_fetch(pc, w, c);
    chk("fetch_valid", {31'b0, instr_valid}, 1);
    chk("fetch_instr", instr, w);
    chk("fetch_fault", {31'b0, fault}, {31'b0, c != 0});
    chk("fetch_code", {30'b0, fault_code}, {30'b0, c});
  endtask

  initial begin
    logic [31:0] held;
    int n, kind;
    tick();
    tick();
    rst = 0;
    chk("rst_instr", instr, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_code", {30'b0, fault_code}, 0);
    chk("rst_len", {21'b0, prog_len}, 0);
    chk("rst_ovf", {31'b0, load_ovf}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    fetch_req = 1;
    tick();
    fetch_req = 0;
    chk("idle_fetch_ignored", {31'b0, instr_valid}, 0);

    prog = '{8'h00, 8'h00, 8'h08, 8'h20, 8'h8C, 8'h22, 8'h03, 8'hE8};
    do_load(0);
    fetch(4);
    chk("basic_word", instr, 32'h8C2203E8);
    fetch(2);
    fetch(32'h400);
    fetch(8);
    chk("beyond_code", {30'b0, fault_code}, 3);

    fetch(0);
    chk("stall_setup", instr, 32'h00000820);
    fetch_stall = 1;
    fetch_req = 1;
    fetch_pc = 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", {31'b0, ready}, 0);
      chk("stall_instr", instr, 32'h00000820);
      chk("stall_valid", {31'b0, instr_valid}, 1);
    end
    fetch_stall = 0;
    fetch_req = 0;
    tick();
    chk("idle_valid", {31'b0, instr_valid}, 0);
    chk("idle_instr_held", instr, 32'h00000820);

    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back(byte'(8'h10 + i));
    prog[0] = 8'hAB;
    do_load(1);
    fetch(0);
    chk("reload_word0", instr, 32'hAB111213);

    for (int i = 0; i < 3; i++) begin
      load_en = 1;
      load_data = 8'($urandom);
      model_mem[i] = load_data;
      tick();
    end
    rst = 1;
    load_en = 0;
    tick();
    rst = 0;
    model_len = 0;
    model_ovf = 0;
    chk("midload_rst_len", {21'b0, prog_len}, 0);
    chk("midload_rst_ready", {31'b0, ready}, 0);
    fetch_req = 1;
    fetch_pc = 0;
    tick();
    tick();
    fetch_req = 0;
    chk("midload_rst_fetch_ignored", {31'b0, instr_valid}, 0);

    prog.delete();
    for (int i = 0; i < DEPTH + 2; i++) prog.push_back(byte'($urandom));
    do_load(0);
    fetch(DEPTH - 4);
    fetch(DEPTH);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(4, 48);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(byte'($urandom));
      do_load(0);
      for (int k = 0; k < 10; k++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: fetch(32'(4 * $urandom_range(0, 20)));
          1: fetch($urandom | 32'h1);
          2: fetch($urandom | 32'h400);
          default: fetch(32'(4 * $urandom_range(0, n / 4 - 1)));
        endcase
        if ($urandom_range(0, 2) == 0) begin
          held = instr;
          tick();
          chk("gap_valid", {31'b0, instr_valid}, 0);
          chk("gap_instr", instr, held);
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/prog_instr_mem.md
PROG_INSTR_MEM -- requirements
Module: prog_instr_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in bytes (power of two, >= 8).
REQ-002 SHALL have parameter AW, default 10, meaning byte-address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port load_en, input, 1, meaning a byte is presented on load_data this cycle.
REQ-006 SHALL have port load_data, input, 8, meaning the program byte to store at the load pointer.
REQ-007 SHALL have port fetch_req, input, 1, meaning a fetch request at fetch_pc.
REQ-008 SHALL have port fetch_pc, input, 32, meaning the byte address of the instruction.
REQ-009 SHALL have port fetch_stall, input, 1, meaning the consumer cannot accept new output; hold it.
REQ-010 SHALL have port ready, output, 1, meaning the block is in RUN and not stalled, so fetch_req is accepted.
REQ-011 SHALL have port instr, output, 32, meaning the fetched instruction word.
REQ-012 SHALL have port instr_valid, output, 1, meaning instr, fault and fault_code are valid.
REQ-013 SHALL have port fault, output, 1, meaning the fetched word is substituted due to an error.
REQ-014 SHALL have port fault_code, output, 2, meaning 00 none, 01 misaligned, 10 out of range, 11 beyond loaded program.
REQ-015 SHALL have port prog_len, output, AW+1, meaning the number of bytes loaded by the last completed load.
REQ-016 SHALL have port load_ovf, output, 1, meaning the last load supplied more than DEPTH bytes.

Function
REQ-017 SHALL implement states IDLE, LOAD and RUN.
REQ-018 SHALL move from IDLE or RUN to LOAD when load_en=1, reset the load pointer to 0, and write the first byte at address 0 in that same cycle.
REQ-019 SHALL, in LOAD with load_en=1, write load_data at the load pointer and then increment the pointer.
REQ-020 SHALL, in LOAD, drop any write when the pointer equals DEPTH, set load_ovf=1, and hold the pointer at DEPTH.
REQ-021 SHALL, in LOAD with load_en=0, latch prog_len equal to the pointer and move to RUN on the next edge.
REQ-022 SHALL clear load_ovf when a new load begins.
REQ-023 SHALL drive ready=1 only in RUN with fetch_stall=0.
REQ-024 SHALL ignore fetch_req when ready=0.
REQ-025 SHALL give accepted fetches exactly one cycle of latency: instr, fault and fault_code are registered, and instr_valid=1 on the following cycle.
REQ-026 SHALL drive instr big-endian, as {mem[a], mem[a+1], mem[a+2], mem[a+3]} with a = fetch_pc[AW-1:0].
REQ-027 SHALL evaluate faults with priority misaligned > out of range > beyond program.
REQ-028 SHALL signal misaligned when fetch_pc[1:0] != 0.
REQ-029 SHALL signal out of range when fetch_pc[31:AW] != 0.
REQ-030 SHALL signal beyond program when a+4 > prog_len.
REQ-031 SHALL, on any fault, drive instr=32'h00000000 (NOP) with fault=1 and instr_valid=1; the block SHALL not wrap addresses.
REQ-032 SHALL, while fetch_stall=1, hold instr, instr_valid, fault and fault_code unchanged.
REQ-033 SHALL, when fetch_stall=0 and no fetch is accepted, drive instr_valid=0 on the next cycle and leave instr unchanged.
REQ-034 SHALL, when load_en=1 and fetch_req=1 in RUN in the same cycle, give the load priority: enter LOAD, drop the fetch, and drive instr_valid=0 next cycle.
REQ-035 SHALL abandon a fetch in flight when entering LOAD, with no valid output produced.

Reset
REQ-036 SHALL, on rst=1 at a clock edge, set state=IDLE, load pointer=0, prog_len=0, load_ovf=0, instr=0, instr_valid=0, fault=0 and fault_code=00.
REQ-037 SHALL leave memory contents unchanged by reset.
REQ-038 SHALL, when rst=1 arrives mid-LOAD, discard the load in progress, leave prog_len=0, and require a new load before fetches are accepted.
REQ-039 SHALL give rst priority over load_en, fetch_req and fetch_stall.

Verification
REQ-040 SHALL cover a basic load and fetch: load bytes 00 00 08 20 8C 22 03 E8, then fetch_pc=4 -> next cycle instr=8C2203E8, instr_valid=1, fault=0, prog_len=8.
REQ-041 SHALL cover fault cases after an 8-byte load: fetch_pc=2 -> fault_code=01; fetch_pc=32'h00000400 -> 10; fetch_pc=8 -> 11; instr=0 in each case.
REQ-042 SHALL cover stall: with a fetch accepted at pc=0 and fetch_stall=1 for 3 cycles, instr=00000820 stays held with ready=0, and new fetch_req is ignored.
REQ-043 SHALL cover overflow: load DEPTH+2 bytes -> load_ovf=1, prog_len=DEPTH, and the last word fetch at DEPTH-4 returns the last bytes written before overflow.
REQ-044 SHALL cover reset mid-load: rst after 3 loaded bytes -> state IDLE, prog_len=0, and fetch_req is ignored until a new load completes.
REQ-045 SHALL cover simultaneous events: load_en=1 and fetch_req=1 together in RUN -> no instr_valid next cycle, the LOAD byte is written at address 0, and the old prog_len is replaced on completion.
